// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO; mult/div take MULT_CYCLES/DIV_CYCLES of busy, mthi/mtlo take one edge.
// Define MD_DIVZERO_HOLD_EN to leave HI/LO untouched on divide by zero.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MCNT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DCNT = CW'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          busy_q, busy_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] dvd, dvs, uq, ur;
  logic        is_signed_div;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
  always_comb begin
    prod_s        = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u        = {32'd0, a_q} * {32'd0, b_q};
    is_signed_div = (op_q == OP_DIV);
    dvd           = (is_signed_div && a_q[31]) ? (32'd0 - a_q) : a_q;
    dvs           = (is_signed_div && b_q[31]) ? (32'd0 - b_q) : b_q;
    uq            = (dvs == 32'd0) ? 32'hFFFF_FFFF : dvd / dvs;
    ur            = (dvs == 32'd0) ? dvd : dvd % dvs;
    res_wr        = 1'b1;
    res_hi        = prod_u[63:32];
    res_lo        = prod_u[31:0];
    case (op_q)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b_q == 32'd0) begin
`ifdef MD_DIVZERO_HOLD_EN
          res_wr = 1'b0;
`else
          res_wr = 1'b1;
`endif
          res_hi = a_q;
          res_lo = 32'hFFFF_FFFF;
        end else if (is_signed_div) begin
          res_lo = (a_q[31] ^ b_q[31]) ? (32'd0 - uq) : uq;
          res_hi = a_q[31] ? (32'd0 - ur) : ur;
        end else begin
          res_lo = uq;
          res_hi = ur;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_d    = md_op;
              a_d     = a;
              b_d     = b;
              cnt_d   = (md_op == OP_MULT || md_op == OP_MULTU) ? MCNT : DCNT;
              state_d = RUN;
              busy_d  = 1'b1;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (res_wr) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: HI/LO results, busy timing, async reset abort.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] hi_m, lo_m;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start while busy is a hazard-unit bug; the bench never does it.
  always @(posedge clk)
    if (rst_n && start && busy) chk("protocol_start_in_run", {31'd0, start}, 32'd0);

  task automatic check_state(input string tag, input logic exp_busy);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, exp_busy});
    chk({tag, ".hi"}, hi, hi_m);
    chk({tag, ".lo"}, lo, lo_m);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input int n, input logic [31:0] eh,
                        input logic [31:0] el, input bit jitter);
    start = 1'b1; md_op = op; a = va; b = vb;
    tick();
    start = 1'b0; md_op = 3'd0;
    for (int i = 0; i < n; i++) begin
      check_state({tag, ".run"}, 1'b1);
      if (jitter) begin
        a = $urandom;
        b = $urandom;
      end
      tick();
    end
    hi_m = eh;
    lo_m = el;
    check_state({tag, ".done"}, 1'b0);
  endtask

  task automatic mt_op(input string tag, input logic [2:0] op, input logic [31:0] va);
    start = 1'b1; md_op = op; a = va; b = 32'h5555_5555;
    tick();
    start = 1'b0; md_op = 3'd0;
    if (op == 3'd5) hi_m = va;
    if (op == 3'd6) lo_m = va;
    check_state(tag, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; md_op = 3'd0; a = '0; b = '0;
    hi_m = '0; lo_m = '0;
    #12;
    check_state("reset", 1'b0);
    rst_n = 1'b1;
    tick();

    run_op("mult_neg3x5", 3'd1, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("multu_max_x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    mt_op("mthi", 3'd5, 32'h1234_5678);
    mt_op("reserved_op", 3'd7, 32'hDEAD_BEEF);

    run_op("div_neg7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_min_neg1", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0);
    run_op("div_7_neg2", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_max_10", 3'd4, 32'hFFFF_FFFF, 32'd10, 10, 32'd5, 32'h1999_9999, 1'b0);

    mt_op("mthi_pre", 3'd5, 32'hAAAA_0000);
    mt_op("mtlo_pre", 3'd6, 32'h0000_BBBB);
`ifdef MD_DIVZERO_HOLD_EN
    run_op("divu_by_zero", 3'd4, 32'd7, 32'd0, 10, 32'hAAAA_0000, 32'h0000_BBBB, 1'b0);
`else
    run_op("divu_by_zero", 3'd4, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF, 1'b0);
`endif

    run_op("mult_6x7_jitter", 3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42, 1'b1);
    run_op("multu_2x3_b2b", 3'd2, 32'd2, 32'd3, 5, 32'd0, 32'd6, 1'b0);

    // Abort a divide in its fourth busy cycle.
    start = 1'b1; md_op = 3'd3; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0; md_op = 3'd0;
    repeat (3) tick();
    chk("abort.busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    hi_m = '0;
    lo_m = '0;
    check_state("abort.in_reset", 1'b0);
    #2 rst_n = 1'b1;
    repeat (12) tick();
    check_state("abort.after", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
